// File: rtl/int_ctrl.sv
// Push-button interrupt controller: synchronise and debounce four buttons, latch presses,
// and present the highest-priority unmasked one to the CPU, one at a time until RET.
module int_ctrl #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [15:0] VEC_BASE        = 16'h0f80,
  parameter logic [15:0] VEC_STRIDE      = 16'h0020
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  buttons_raw,
  input  logic [3:0]  int_mask,
  input  logic        int_ack,
  input  logic        int_ret,
  output logic        int_req,
  output logic [1:0]  int_id,
  output logic [15:0] int_vector,
  output logic        int_active,
  output logic [3:0]  pending
);
  // state   | meaning
  // IDLE    | no request outstanding, waiting for an unmasked pending press
  // REQ     | int_req presented, id/vector frozen until int_ack
  // SERVICE | handler running, no new requests until int_ret
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 16'd1);
  localparam logic [15:0]   VEC_RESET = VEC_BASE + 16'd3 * VEC_STRIDE;

  function automatic logic [15:0] vec_of(input logic [1:0] id);
    return VEC_BASE + 16'(2'd3 - id) * VEC_STRIDE;
  endfunction

  logic [3:0]    sync_a, sync, stable, stable_d;
  logic [CW-1:0] cnt [4];
  logic [3:0]    cand, pending_nxt;
  logic [1:0]    sel, id_nxt;
  logic [15:0]   vec_nxt;
  logic          req_nxt, active_nxt, ack_take;
  state_t        state, state_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a   <= '0;
      sync     <= '0;
      stable   <= '0;
      stable_d <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      sync_a   <= buttons_raw;
      sync     <= sync_a;
      stable_d <= stable;
      for (int i = 0; i < 4; i++) begin
        if (sync[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= ~stable[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign cand = pending & ~int_mask;

  always_comb begin
    sel = 2'd0;
    for (int i = 0; i < 4; i++) if (cand[i]) sel = 2'(i);
  end

  always_comb begin
    state_nxt  = state;
    req_nxt    = int_req;
    id_nxt     = int_id;
    vec_nxt    = int_vector;
    active_nxt = int_active;
    ack_take   = 1'b0;
    case (state)
      IDLE: if (|cand) begin
        state_nxt = REQ;
        req_nxt   = 1'b1;
        id_nxt    = sel;
        vec_nxt   = vec_of(sel);
      end
      REQ: if (int_ack) begin
        state_nxt  = SERVICE;
        req_nxt    = 1'b0;
        active_nxt = 1'b1;
        ack_take   = 1'b1;
      end
      SERVICE: if (int_ret) begin
        state_nxt  = IDLE;
        active_nxt = 1'b0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A fresh press landing on the ack edge must survive the clear.
  always_comb begin
    pending_nxt = pending;
    if (ack_take) pending_nxt[int_id] = 1'b0;
    pending_nxt = pending_nxt | (stable & ~stable_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      int_req    <= 1'b0;
      int_id     <= 2'd0;
      int_vector <= VEC_RESET;
      int_active <= 1'b0;
      pending    <= '0;
    end else begin
      state      <= state_nxt;
      int_req    <= req_nxt;
      int_id     <= id_nxt;
      int_vector <= vec_nxt;
      int_active <= active_nxt;
      pending    <= pending_nxt;
    end
  end
endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl with a short debounce: directed scenarios with hand-computed values,
// then random traffic checked against a behavioural model.
module tb_int_ctrl;
  localparam int D = 4;
  localparam logic [15:0] V0 = 16'h0fe0, V1 = 16'h0fc0, V2 = 16'h0fa0, V3 = 16'h0f80;

  logic        clk = 1'b0;
  logic        rst_n, int_ack, int_ret;
  logic [3:0]  buttons_raw, int_mask;
  logic        int_req, int_active;
  logic [1:0]  int_id;
  logic [15:0] int_vector;
  logic [3:0]  pending;
  logic [23:0] obs, expv;
  int total = 0, bad = 0;

  int_ctrl #(.DEBOUNCE_CYCLES(16'(D))) dut (
    .clk(clk), .rst_n(rst_n), .buttons_raw(buttons_raw), .int_mask(int_mask),
    .int_ack(int_ack), .int_ret(int_ret), .int_req(int_req), .int_id(int_id),
    .int_vector(int_vector), .int_active(int_active), .pending(pending)
  );

  always #5 clk = ~clk;
  assign obs = {int_req, int_id, int_vector, int_active, pending};

  // Reference model: a press is accepted after D consecutive synchronised samples that
  // disagree with the accepted level; mode 0 = idle, 1 = waiting for ack, 2 = in handler.
  logic [3:0]  m_sa, m_s, m_stable, m_stable_prev, m_pend;
  int          m_run [4];
  int          m_mode;
  logic        m_req, m_active;
  logic [1:0]  m_id;
  logic [15:0] m_vec;

  task automatic model_reset();
    m_sa = 0; m_s = 0; m_stable = 0; m_stable_prev = 0; m_pend = 0;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
    m_mode = 0; m_req = 0; m_active = 0; m_id = 0; m_vec = V0;
  endtask

  task automatic model_step();
    logic [3:0] n_pend, n_stable;
    int k;
    n_pend = m_pend;
    if (m_mode == 1 && int_ack) n_pend[m_id] = 1'b0;
    n_pend = n_pend | (m_stable & ~m_stable_prev);
    n_stable = m_stable;
    for (int i = 0; i < 4; i++) begin
      if (m_s[i] != m_stable[i]) begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] == D) begin n_stable[i] = ~m_stable[i]; m_run[i] = 0; end
      end else m_run[i] = 0;
    end
    if (m_mode == 0) begin
      if ((m_pend & ~int_mask) != 0) begin
        k = 0;
        for (int i = 0; i < 4; i++) if (m_pend[i] && !int_mask[i]) k = i;
        m_id = 2'(k); m_vec = 16'(32'h0f80 + (3 - k) * 32'h20);
        m_req = 1; m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (int_ack) begin m_mode = 2; m_req = 0; m_active = 1; end
    end else begin
      if (int_ret) begin m_mode = 0; m_active = 0; end
    end
    m_stable_prev = m_stable; m_stable = n_stable;
    m_s = m_sa; m_sa = buttons_raw; m_pend = n_pend;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset(); else model_step();
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse_ack(); int_ack = 1; step(1); int_ack = 0; endtask
  task automatic pulse_ret(); int_ret = 1; step(1); int_ret = 0; endtask

  task automatic test_reset();
    rst_n = 0; step(2);
    total++; if (obs !== {1'b0, 2'd0, V0, 1'b0, 4'b0}) begin bad++; $display("FAIL reset_held got=%h want=%h", obs, {1'b0, 2'd0, V0, 1'b0, 4'b0}); end
    rst_n = 1; step(2);
    total++; if (obs !== {1'b0, 2'd0, V0, 1'b0, 4'b0}) begin bad++; $display("FAIL reset_idle got=%h want=%h", obs, {1'b0, 2'd0, V0, 1'b0, 4'b0}); end
  endtask

  task automatic test_single_press();
    buttons_raw = 4'b0100; step(3 + D);
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL press_early got=%b want=0", int_req); end
    step(1);
    total++; if (obs !== {1'b1, 2'd2, V2, 1'b0, 4'b0100}) begin bad++; $display("FAIL press_req got=%h want=%h", obs, {1'b1, 2'd2, V2, 1'b0, 4'b0100}); end
  endtask

  task automatic test_handshake();
    pulse_ack(); buttons_raw = 0;
    total++; if (obs !== {1'b0, 2'd2, V2, 1'b1, 4'b0}) begin bad++; $display("FAIL hs_ack got=%h want=%h", obs, {1'b0, 2'd2, V2, 1'b1, 4'b0}); end
    pulse_ret();
    total++; if (obs !== {1'b0, 2'd2, V2, 1'b0, 4'b0}) begin bad++; $display("FAIL hs_ret got=%h want=%h", obs, {1'b0, 2'd2, V2, 1'b0, 4'b0}); end
    step(D + 4);
    total++; if (obs !== {1'b0, 2'd2, V2, 1'b0, 4'b0}) begin bad++; $display("FAIL hs_quiet got=%h want=%h", obs, {1'b0, 2'd2, V2, 1'b0, 4'b0}); end
  endtask

  task automatic test_priority();
    buttons_raw = 4'b1001; step(4 + D);
    total++; if (obs !== {1'b1, 2'd3, V3, 1'b0, 4'b1001}) begin bad++; $display("FAIL prio_first got=%h want=%h", obs, {1'b1, 2'd3, V3, 1'b0, 4'b1001}); end
    pulse_ack(); pulse_ret();
    total++; if (obs !== {1'b0, 2'd3, V3, 1'b0, 4'b0001}) begin bad++; $display("FAIL prio_ret got=%h want=%h", obs, {1'b0, 2'd3, V3, 1'b0, 4'b0001}); end
    step(1);
    total++; if (obs !== {1'b1, 2'd0, V0, 1'b0, 4'b0001}) begin bad++; $display("FAIL prio_second got=%h want=%h", obs, {1'b1, 2'd0, V0, 1'b0, 4'b0001}); end
    buttons_raw = 0; pulse_ack(); pulse_ret(); step(D + 4);
  endtask

  task automatic test_mask();
    int_mask = 4'b1000; buttons_raw = 4'b1001; step(4 + D);
    total++; if (obs !== {1'b1, 2'd0, V0, 1'b0, 4'b1001}) begin bad++; $display("FAIL mask_req got=%h want=%h", obs, {1'b1, 2'd0, V0, 1'b0, 4'b1001}); end
    pulse_ack(); pulse_ret(); step(2);
    total++; if (obs !== {1'b0, 2'd0, V0, 1'b0, 4'b1000}) begin bad++; $display("FAIL mask_hold got=%h want=%h", obs, {1'b0, 2'd0, V0, 1'b0, 4'b1000}); end
    int_mask = 0; step(1);
    total++; if (obs !== {1'b1, 2'd3, V3, 1'b0, 4'b1000}) begin bad++; $display("FAIL mask_unmask got=%h want=%h", obs, {1'b1, 2'd3, V3, 1'b0, 4'b1000}); end
    buttons_raw = 0; pulse_ack(); pulse_ret(); step(D + 4);
  endtask

  task automatic test_no_preempt();
    buttons_raw = 4'b0010; step(4 + D);
    buttons_raw = 4'b1010; step(D + 4);
    int_mask = 4'b0010; step(2);
    total++; if (obs !== {1'b1, 2'd1, V1, 1'b0, 4'b1010}) begin bad++; $display("FAIL preempt_hold got=%h want=%h", obs, {1'b1, 2'd1, V1, 1'b0, 4'b1010}); end
    int_mask = 0; buttons_raw = 0; pulse_ack(); pulse_ret(); step(1);
    total++; if (obs !== {1'b1, 2'd3, V3, 1'b0, 4'b1000}) begin bad++; $display("FAIL preempt_next got=%h want=%h", obs, {1'b1, 2'd3, V3, 1'b0, 4'b1000}); end
    pulse_ack(); pulse_ret(); step(D + 4);
  endtask

  task automatic test_bounce();
    for (int n = 0; n < 3; n++) begin
      buttons_raw = 4'b0101; step(2); buttons_raw = 0; step(2);
    end
    step(D + 6);
    total++; if (obs !== {1'b0, 2'd3, V3, 1'b0, 4'b0}) begin bad++; $display("FAIL bounce got=%h want=%h", obs, {1'b0, 2'd3, V3, 1'b0, 4'b0}); end
  endtask

  task automatic test_no_nesting();
    buttons_raw = 4'b0001; step(4 + D); pulse_ack();
    buttons_raw = 4'b0101; step(D + 4);
    total++; if (obs !== {1'b0, 2'd0, V0, 1'b1, 4'b0100}) begin bad++; $display("FAIL nest_service got=%h want=%h", obs, {1'b0, 2'd0, V0, 1'b1, 4'b0100}); end
    pulse_ret();
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL nest_ret_cycle got=%b want=0", int_req); end
    step(1);
    total++; if (obs !== {1'b1, 2'd2, V2, 1'b0, 4'b0100}) begin bad++; $display("FAIL nest_after got=%h want=%h", obs, {1'b1, 2'd2, V2, 1'b0, 4'b0100}); end
    buttons_raw = 0; pulse_ack(); pulse_ret(); step(D + 4);
  endtask

  task automatic test_ignored();
    pulse_ack(); pulse_ret();
    total++; if (obs !== {1'b0, 2'd2, V2, 1'b0, 4'b0}) begin bad++; $display("FAIL ign_idle got=%h want=%h", obs, {1'b0, 2'd2, V2, 1'b0, 4'b0}); end
    buttons_raw = 4'b1000; step(4 + D); buttons_raw = 0; pulse_ret();
    total++; if (obs !== {1'b1, 2'd3, V3, 1'b0, 4'b1000}) begin bad++; $display("FAIL ign_ret_req got=%h want=%h", obs, {1'b1, 2'd3, V3, 1'b0, 4'b1000}); end
    int_ack = 1; int_ret = 1; step(1); int_ack = 0; int_ret = 0;
    total++; if (obs !== {1'b0, 2'd3, V3, 1'b1, 4'b0}) begin bad++; $display("FAIL ign_both got=%h want=%h", obs, {1'b0, 2'd3, V3, 1'b1, 4'b0}); end
    pulse_ack();
    total++; if (obs !== {1'b0, 2'd3, V3, 1'b1, 4'b0}) begin bad++; $display("FAIL ign_ack_svc got=%h want=%h", obs, {1'b0, 2'd3, V3, 1'b1, 4'b0}); end
    pulse_ret(); step(D + 4);
  endtask

  task automatic test_ack_same_id();
    buttons_raw = 4'b0010; step(4 + D);
    buttons_raw = 0; step(D + 4);
    buttons_raw = 4'b0010; step(2 + D);
    int_ack = 1; step(1); int_ack = 0;
    total++; if (obs !== {1'b0, 2'd1, V1, 1'b1, 4'b0010}) begin bad++; $display("FAIL same_id_ack got=%h want=%h", obs, {1'b0, 2'd1, V1, 1'b1, 4'b0010}); end
    pulse_ret(); step(1);
    total++; if (obs !== {1'b1, 2'd1, V1, 1'b0, 4'b0010}) begin bad++; $display("FAIL same_id_rereq got=%h want=%h", obs, {1'b1, 2'd1, V1, 1'b0, 4'b0010}); end
    buttons_raw = 0; pulse_ack(); pulse_ret(); step(D + 4);
  endtask

  task automatic test_reset_mid();
    buttons_raw = 4'b0100; step(4 + D);
    #2 rst_n = 0;
    #1;
    total++; if (obs !== {1'b0, 2'd0, V0, 1'b0, 4'b0}) begin bad++; $display("FAIL rst_mid got=%h want=%h", obs, {1'b0, 2'd0, V0, 1'b0, 4'b0}); end
    step(2); rst_n = 1; step(3 + D);
    total++; if (obs !== {1'b0, 2'd0, V0, 1'b0, 4'b0100}) begin bad++; $display("FAIL rst_early got=%h want=%h", obs, {1'b0, 2'd0, V0, 1'b0, 4'b0100}); end
    step(1);
    total++; if (obs !== {1'b1, 2'd2, V2, 1'b0, 4'b0100}) begin bad++; $display("FAIL rst_rereq got=%h want=%h", obs, {1'b1, 2'd2, V2, 1'b0, 4'b0100}); end
    buttons_raw = 0; pulse_ack(); pulse_ret(); step(D + 4);
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      expv = {m_req, m_id, m_vec, m_active, m_pend};
      total++; if (obs !== expv) begin bad++; $display("FAIL random cyc=%0d got=%h want=%h", n, obs, expv); end
      if ($urandom_range(0, 11) == 0) buttons_raw[$urandom_range(0, 3)] = ~buttons_raw[$urandom_range(0, 3)];
      if ($urandom_range(0, 31) == 0) int_mask = 4'($urandom_range(0, 15));
      int_ack = ($urandom_range(0, 3) == 0);
      int_ret = ($urandom_range(0, 5) == 0);
      step(1);
    end
    int_ack = 0; int_ret = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    rst_n = 0; buttons_raw = 0; int_mask = 0; int_ack = 0; int_ret = 0;
    @(negedge clk);
    test_reset();
    test_single_press();
    test_handshake();
    test_priority();
    test_mask();
    test_no_preempt();
    test_bounce();
    test_no_nesting();
    test_ignored();
    test_ack_same_id();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
